key_load_ctrl: RTL and testbench

KEY_LOAD_CTRL -- requirements
Module: key_load_ctrl

---
 rtl/key_ctrl_pkg.sv | 21 ++
 rtl/key_shreg.sv | 48 ++++
 rtl/key_load_ctrl.sv | 152 +++++++++++++++
 tb/tb_key_load_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/key_ctrl_pkg.sv
// Shared definitions for the key-load controller: state encoding, parameter defaults
// and the bit-counter width helper. Optional parity checking is enabled by KEY_PARITY_CHECK_EN.
package key_ctrl_pkg;

  localparam int KEY_W_DEFAULT     = 10;
  localparam int MAX_RETRY_DEFAULT = 3;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_CHECK   = 3'd2,
    ST_ACTIVE  = 3'd3,
    ST_LOCKOUT = 3'd4
  } key_state_e;

  // Counter must reach KEY_W+1 (parity beat) without wrapping.
  function automatic int cnt_width(input int key_w);
    return $clog2(key_w + 2);
  endfunction

endpackage

// File: rtl/key_shreg.sv
// Shadow shift register and saturating beat counter for the serial key loader.
// Bits enter at the LSB, so the first (MSB-first) bit ends up at the top.
module key_shreg
  import key_ctrl_pkg::*;
#(
  parameter int SH_W  = KEY_W_DEFAULT,
  parameter int CNT_W = cnt_width(KEY_W_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             shift_en,
  input  logic             bit_in,
  output logic [SH_W-1:0]  shadow,
  output logic [CNT_W-1:0] cnt
);

  logic [SH_W-1:0]  shadow_q, shadow_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    shadow_d = shadow_q;
    cnt_d    = cnt_q;
    if (clr) begin
      shadow_d = '0;
      cnt_d    = '0;
    end else if (shift_en) begin
      shadow_d = {shadow_q[SH_W-2:0], bit_in};
      if (cnt_q != '1) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end

  assign shadow = shadow_q;
  assign cnt    = cnt_q;

endmodule

// File: rtl/key_load_ctrl.sv
// Key-load controller: serially loads a logic-locking key, optionally parity-checks it
// (KEY_PARITY_CHECK_EN) with retry/lockout, and drives the verified key onto the key gates.
module key_load_ctrl
  import key_ctrl_pkg::*;
#(
  parameter int KEY_W     = KEY_W_DEFAULT,
  parameter int MAX_RETRY = MAX_RETRY_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             key_clr,
  input  logic             kin_valid,
  input  logic             kin_bit,
  output logic             kin_ready,
  output logic [KEY_W-1:0] key_out,
  output logic             key_valid,
  output logic             busy,
  output logic             err,
  output logic             lockout,
  output logic [2:0]       state_o
);

  // Handshake: a bit is consumed on every cycle where kin_valid && kin_ready;
  // kin_ready is high only in LOAD, and key_clr suppresses a coincident beat.

  localparam logic [2:0] IDLE    = ST_IDLE;
  localparam logic [2:0] LOAD    = ST_LOAD;
  localparam logic [2:0] CHECK   = ST_CHECK;
  localparam logic [2:0] ACTIVE  = ST_ACTIVE;
  localparam logic [2:0] LOCKOUT = ST_LOCKOUT;

`ifdef KEY_PARITY_CHECK_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int SH_W  = KEY_W + PAR_W;
  localparam int CNT_W = cnt_width(KEY_W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(SH_W - 1);

  logic [2:0]       state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic [SH_W-1:0]  shadow;
  logic [CNT_W-1:0] cnt;
  logic             beat, last_beat, sh_clr, chk_pass;

  assign kin_ready = (state_q == LOAD);
  assign beat      = kin_valid && kin_ready && !key_clr;
  assign last_beat = beat && (cnt == LAST_CNT);
  assign sh_clr    = ((state_q == IDLE) && start) ||
                     (key_clr && ((state_q == LOAD) || (state_q == ACTIVE)));

  key_shreg #(
    .SH_W  (SH_W),
    .CNT_W (CNT_W)
  ) u_shreg (
    .clk      (clk),
    .rst      (rst),
    .clr      (sh_clr),
    .shift_en (beat),
    .bit_in   (kin_bit),
    .shadow   (shadow),
    .cnt      (cnt)
  );

`ifdef KEY_PARITY_CHECK_EN
  localparam int RTY_W = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
  logic [RTY_W-1:0] retry_q, retry_d;
  logic             err_q, err_d;

  // Even parity across key and parity bit.
  assign chk_pass = ~(^shadow);
`else
  logic unused_cfg;
  assign unused_cfg = (MAX_RETRY > 0);
  assign chk_pass   = 1'b1;
`endif

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
`ifdef KEY_PARITY_CHECK_EN
    retry_d = retry_q;
    err_d   = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (start) state_d = LOAD;
      end
      LOAD: begin
        if (key_clr)        state_d = IDLE;
        else if (last_beat) state_d = CHECK;
      end
      CHECK: begin
        if (chk_pass) begin
          key_d   = shadow[SH_W-1 -: KEY_W];
          state_d = ACTIVE;
`ifdef KEY_PARITY_CHECK_EN
          retry_d = '0;
        end else begin
          err_d   = 1'b1;
          retry_d = retry_q + RTY_W'(1);
          state_d = (retry_d == RTY_W'(MAX_RETRY)) ? LOCKOUT : IDLE;
`endif
        end
      end
      ACTIVE: begin
        if (key_clr) begin
          key_d   = '0;
          state_d = IDLE;
        end
      end
      LOCKOUT: state_d = LOCKOUT;
      default: begin
        key_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
`ifdef KEY_PARITY_CHECK_EN
      retry_q <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
`ifdef KEY_PARITY_CHECK_EN
      retry_q <= retry_d;
      err_q   <= err_d;
`endif
    end
  end

  assign key_out   = key_q;
  assign key_valid = (state_q == ACTIVE);
  assign busy      = (state_q == LOAD) || (state_q == CHECK);
  assign state_o   = state_q;
`ifdef KEY_PARITY_CHECK_EN
  assign err       = err_q;
  assign lockout   = (state_q == LOCKOUT);
`else
  assign err       = 1'b0;
  assign lockout   = 1'b0;
`endif

endmodule

// File: tb/tb_key_load_ctrl.sv
// Directed bench for key_load_ctrl; parity/lockout steps run when KEY_PARITY_CHECK_EN is defined.
module tb_key_load_ctrl;

  localparam int KEY_W = 10;
  localparam logic [2:0] S_IDLE = 3'd0, S_LOAD = 3'd1, S_CHECK = 3'd2,
                         S_ACTIVE = 3'd3, S_LOCKOUT = 3'd4;

  logic             clk = 1'b0;
  logic             rst, start, key_clr, kin_valid, kin_bit;
  logic             kin_ready, key_valid, busy, err, lockout;
  logic [KEY_W-1:0] key_out;
  logic [2:0]       state_o;

  int checks   = 0;
  int failures = 0;
  logic err_seen = 1'b0;

  key_load_ctrl #(.KEY_W(KEY_W), .MAX_RETRY(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .key_clr   (key_clr),
    .kin_valid (kin_valid),
    .kin_bit   (kin_bit),
    .kin_ready (kin_ready),
    .key_out   (key_out),
    .key_valid (key_valid),
    .busy      (busy),
    .err       (err),
    .lockout   (lockout),
    .state_o   (state_o)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

`ifndef KEY_PARITY_CHECK_EN
  always @(negedge clk) begin
    if (rst === 1'b0 && (err !== 1'b0 || lockout !== 1'b0)) err_seen = 1'b1;
  end
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic b);
    kin_valid = 1'b1;
    kin_bit   = b;
    step();
    kin_valid = 1'b0;
    kin_bit   = 1'b0;
  endtask

  // Drives start then the key MSB first; appends the parity bit when parity is built in.
  task automatic load_key(input logic [KEY_W-1:0] key, input logic par);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = KEY_W - 1; i >= 0; i--) beat(key[i]);
`ifdef KEY_PARITY_CHECK_EN
    beat(par);
`else
    if (par === 1'bx) $display("parity bit unused");
`endif
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"},     32'(state_o),   32'(S_IDLE));
    chk({tag, "_key_out"},   32'(key_out),   32'h0);
    chk({tag, "_key_valid"}, 32'(key_valid), 32'h0);
    chk({tag, "_kin_ready"}, 32'(kin_ready), 32'h0);
    chk({tag, "_busy"},      32'(busy),      32'h0);
    chk({tag, "_err"},       32'(err),       32'h0);
    chk({tag, "_lockout"},   32'(lockout),   32'h0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; key_clr = 1'b0; kin_valid = 1'b0; kin_bit = 1'b0;
    step(); step();
    rst = 1'b0;
    chk_reset_outputs("reset");

    // kin_valid in IDLE is not a beat
    kin_valid = 1'b1;
    step(); step();
    kin_valid = 1'b0;
    chk("idle_valid_ignored", 32'(state_o), 32'(S_IDLE));

    // Stalled source holds LOAD, then key_clr aborts
    start = 1'b1;
    step();
    start = 1'b0;
    chk("load_kin_ready", 32'(kin_ready), 32'h1);
    chk("load_busy", 32'(busy), 32'h1);
    repeat (25) step();
    chk("stall_state", 32'(state_o), 32'(S_LOAD));
    key_clr = 1'b1;
    step();
    key_clr = 1'b0;
    chk("stall_abort_state", 32'(state_o), 32'(S_IDLE));

    // Main load 10'h3A5 (six ones, even parity bit 0)
    load_key(10'h3A5, 1'b0);
    chk("final_beat_state", 32'(state_o), 32'(S_CHECK));
    chk("check_busy", 32'(busy), 32'h1);
    chk("check_kin_ready", 32'(kin_ready), 32'h0);
    chk("check_key_valid", 32'(key_valid), 32'h0);
    chk("check_key_out", 32'(key_out), 32'h0);
    step();
    chk("a_key_out", 32'(key_out), 32'h3A5);
    chk("a_key_valid", 32'(key_valid), 32'h1);
    chk("a_busy", 32'(busy), 32'h0);
    chk("a_err", 32'(err), 32'h0);

    // start ignored in ACTIVE
    start = 1'b1; kin_valid = 1'b1; kin_bit = 1'b1;
    step(); step();
    start = 1'b0; kin_valid = 1'b0; kin_bit = 1'b0;
    chk("active_start_state", 32'(state_o), 32'(S_ACTIVE));
    chk("active_key_stable", 32'(key_out), 32'h3A5);

    // key_clr from ACTIVE
    key_clr = 1'b1;
    step();
    key_clr = 1'b0;
    chk("clr_state", 32'(state_o), 32'(S_IDLE));
    chk("clr_key_out", 32'(key_out), 32'h0);
    chk("clr_key_valid", 32'(key_valid), 32'h0);

    // Gappy source, key_clr on the 6th beat cycle wins over the beat
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      kin_valid = 1'b1; kin_bit = 1'(i);
      step();
      kin_valid = 1'b0;
      step();
    end
    chk("gappy_still_load", 32'(state_o), 32'(S_LOAD));
    kin_valid = 1'b1; kin_bit = 1'b1; key_clr = 1'b1;
    step();
    kin_valid = 1'b0; kin_bit = 1'b0; key_clr = 1'b0;
    chk("abort_state", 32'(state_o), 32'(S_IDLE));
    chk("abort_key_out", 32'(key_out), 32'h0);
    chk("abort_busy", 32'(busy), 32'h0);

    // rst after 4 beats of a load
    start = 1'b1;
    step();
    start = 1'b0;
    beat(1'b1); beat(1'b0); beat(1'b1); beat(1'b1);
    chk("midload_state", 32'(state_o), 32'(S_LOAD));
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("midrst");

    // Fresh load 10'h15A (five ones, parity bit 1)
    load_key(10'h15A, 1'b1);
    step();
    chk("b_key_out", 32'(key_out), 32'h15A);
    chk("b_key_valid", 32'(key_valid), 32'h1);
    key_clr = 1'b1;
    step();
    key_clr = 1'b0;

    // Boundary patterns: all ones (ten ones, parity 0) and single LSB (parity 1)
    load_key(10'h3FF, 1'b0);
    step();
    chk("c_key_out", 32'(key_out), 32'h3FF);
    key_clr = 1'b1;
    step();
    key_clr = 1'b0;
    load_key(10'h001, 1'b1);
    step();
    chk("d_key_out", 32'(key_out), 32'h001);
    key_clr = 1'b1;
    step();
    key_clr = 1'b0;

`ifdef KEY_PARITY_CHECK_EN
    // Good parity: 1011001110 + parity 0
    load_key(10'b1011001110, 1'b0);
    step();
    chk("p_good_key_out", 32'(key_out), 32'h2CE);
    chk("p_good_err", 32'(err), 32'h0);
    key_clr = 1'b1;
    step();
    key_clr = 1'b0;

    // Bad parity: single err pulse, back in IDLE
    load_key(10'b1011001110, 1'b1);
    step();
    chk("p_bad_err", 32'(err), 32'h1);
    chk("p_bad_state", 32'(state_o), 32'(S_IDLE));
    chk("p_bad_key_out", 32'(key_out), 32'h0);
    chk("p_bad_lockout", 32'(lockout), 32'h0);
    step();
    chk("p_bad_err_pulse", 32'(err), 32'h0);

    // Second bad, abort (no count), third bad -> lockout
    load_key(10'h3A5, 1'b1);
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    beat(1'b1); beat(1'b1);
    key_clr = 1'b1;
    step();
    key_clr = 1'b0;
    chk("p_abort_lockout", 32'(lockout), 32'h0);
    load_key(10'h3A5, 1'b1);
    step();
    chk("p_lock_lockout", 32'(lockout), 32'h1);
    chk("p_lock_state", 32'(state_o), 32'(S_LOCKOUT));
    chk("p_lock_err", 32'(err), 32'h1);
    start = 1'b1; key_clr = 1'b1;
    step(); step();
    start = 1'b0; key_clr = 1'b0;
    chk("p_lock_sticky", 32'(state_o), 32'(S_LOCKOUT));
    chk("p_lock_kin_ready", 32'(kin_ready), 32'h0);
    chk("p_lock_key_out", 32'(key_out), 32'h0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_reset_outputs("p_lockrst");

    // A pass clears the retry count
    load_key(10'h3A5, 1'b1); step();
    load_key(10'h3A5, 1'b1); step();
    load_key(10'h3A5, 1'b0); step();
    chk("p_pass_clear_valid", 32'(key_valid), 32'h1);
    key_clr = 1'b1;
    step();
    key_clr = 1'b0;
    load_key(10'h3A5, 1'b1); step();
    load_key(10'h3A5, 1'b1); step();
    chk("p_retry_cleared", 32'(lockout), 32'h0);
`else
    chk("np_err_lockout_never", 32'(err_seen), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
